// File: rtl/instr_fetch_stage.sv
// ============================================================================
// instr_fetch_stage
//
// Fetch stage that sits between the program counter and decode.
//
// For each PC value the stage:
//   - issues exactly one instruction-memory read;
//   - captures the returned word in a valid/ready register for decode;
//   - pulses pc_en for one cycle, but only after decode has taken the word.
//
// A flush squashes any fetch that is in flight or being held, so that a branch
// redirect never produces a stale instruction. Only one memory request is
// ever outstanding. With a zero-wait memory each instruction takes at least
// five cycles, one in each of IDLE, REQ, WAIT, HOLD and ADV.
//
// Ports
//   clk          in   1        clock, all state updates on posedge
//   rst          in   1        synchronous active-high reset
//   pc_in        in   PC_W     current PC from the program counter
//   pc_en        out  1        one-cycle pulse, the PC may advance
//   flush        in   1        squash the current fetch (branch redirect)
//   imem_req     out  1        read request to instruction memory
//   imem_addr    out  PC_W     read address, stable while imem_req is high
//   imem_ready   in   1        memory accepts the request this cycle
//   imem_rvalid  in   1        read data valid this cycle
//   imem_rdata   in   INSTR_W  read data
//   id_valid     out  1        id_instr/id_pc valid for decode
//   id_ready     in   1        decode accepts id_instr this cycle
//   id_instr     out  INSTR_W  fetched instruction
//   id_pc        out  PC_W     PC of id_instr
// ============================================================================
module instr_fetch_stage #(
    parameter int PC_W    = 9,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PC_W-1:0]    pc_in,
    output logic               pc_en,
    input  logic               flush,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ready,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] id_instr,
    output logic [PC_W-1:0]    id_pc
);

    // The state encoding is kept as plain constants so that it matches the
    // older tooling that still reads this block.
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_ADV   = 3'd4;
    localparam logic [2:0] S_DRAIN = 3'd5;

    logic [2:0]         state_q,     state_d;
    logic               pc_en_q,     pc_en_d;
    logic               imem_req_q,  imem_req_d;
    logic [PC_W-1:0]    imem_addr_q, imem_addr_d;
    logic               id_valid_q,  id_valid_d;
    logic [INSTR_W-1:0] id_instr_q,  id_instr_d;
    logic [PC_W-1:0]    id_pc_q,     id_pc_d;

    // Next-state and next-output logic.
    //
    // Every output is computed one cycle ahead, so each flop already holds the
    // value that belongs to the state being entered. pc_en_q is high only
    // while in ADV, and because ADV always exits after one cycle, pc_en_d
    // defaults to zero.
    //
    // flush is checked ahead of every normal transition. A request that
    // memory has already accepted still owes one response, so it must be
    // drained rather than abandoned. That is the reason for the REQ-with-ready
    // and WAIT-without-rvalid paths into DRAIN.
    always_comb begin
        state_d     = state_q;
        pc_en_d     = 1'b0;
        imem_req_d  = imem_req_q;
        imem_addr_d = imem_addr_q;
        id_valid_d  = id_valid_q;
        id_instr_d  = id_instr_q;
        id_pc_d     = id_pc_q;

        case (state_q)
            S_IDLE: begin
                // Sample the PC here. It has already moved past the word
                // that was accepted, because ADV has just finished.
                if (!flush) begin
                    state_d     = S_REQ;
                    imem_req_d  = 1'b1;
                    imem_addr_d = pc_in;
                end
            end

            S_REQ: begin
                if (flush) begin
                    imem_req_d = 1'b0;
                    state_d    = imem_ready ? S_DRAIN : S_IDLE;
                end else if (imem_ready) begin
                    imem_req_d = 1'b0;
                    state_d    = S_WAIT;
                end
            end

            S_WAIT: begin
                if (imem_rvalid) begin
                    if (flush) begin
                        // The response has arrived but belongs to the
                        // squashed fetch, so it is dropped.
                        state_d = S_IDLE;
                    end else begin
                        id_instr_d = imem_rdata;
                        id_pc_d    = imem_addr_q;
                        id_valid_d = 1'b1;
                        state_d    = S_HOLD;
                    end
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end

            S_HOLD: begin
                if (flush) begin
                    id_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end else if (id_ready) begin
                    id_valid_d = 1'b0;
                    pc_en_d    = 1'b1;
                    state_d    = S_ADV;
                end
            end

            S_ADV: begin
                state_d = S_IDLE;
            end

            S_DRAIN: begin
                if (imem_rvalid) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d    = S_IDLE;
                imem_req_d = 1'b0;
                id_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_en_q     <= 1'b0;
            imem_req_q  <= 1'b0;
            imem_addr_q <= '0;
            id_valid_q  <= 1'b0;
            id_instr_q  <= '0;
            id_pc_q     <= '0;
        end else begin
            state_q     <= state_d;
            pc_en_q     <= pc_en_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            id_valid_q  <= id_valid_d;
            id_instr_q  <= id_instr_d;
            id_pc_q     <= id_pc_d;
        end
    end

    // pc_en is the only output that has a combinational term.
    //
    // A flush that lands in the ADV cycle must stop the PC from advancing in
    // that same cycle, because the redirect replaces the PC upstream. The
    // registered pulse is therefore gated by flush.
    assign pc_en     = pc_en_q & ~flush;
    assign imem_req  = imem_req_q;
    assign imem_addr = imem_addr_q;
    assign id_valid  = id_valid_q;
    assign id_instr  = id_instr_q;
    assign id_pc     = id_pc_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// ============================================================================
// tb_instr_fetch_stage
//
// Self-checking bench for instr_fetch_stage.
//
// The bench runs in three parts:
//   - directed sequences for the main fetch scenarios;
//   - a long randomized run;
//   - a behavioural model that tracks the fetch as a set of phase flags and
//     predicts every output on every cycle.
//
// The bench also plays the program counter. pc_in steps by one after each
// pc_en pulse that the model expects, and jumps to a new value after a flush
// during the randomized run.
// ============================================================================
module tb_instr_fetch_stage;

    logic        clk;
    logic        rst;
    logic [8:0]  pc_in;
    logic        pc_en;
    logic        flush;
    logic        imem_req;
    logic [8:0]  imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [8:0]  id_pc;

    int checks;
    int fails;
    int pulses;
    bit check_en;

    // Reference model: which phase of the fetch we are in, plus the values
    // that the outputs should show.
    bit          m_req;
    bit          m_wait;
    bit          m_drain;
    bit          m_hold;
    bit          m_adv;
    logic [8:0]  m_addr;
    logic [31:0] m_instr;
    logic [8:0]  m_pc;
    logic [8:0]  pc_model;
    bit          redirect_on_flush;

    instr_fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .pc_in       (pc_in),
        .pc_en       (pc_en),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_instr    (id_instr),
        .id_pc       (id_pc)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compares one observed value against one expected value. Every
    // comparison is counted, and any mismatch is reported.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advances the behavioural model across one clock edge, using the inputs
    // that were applied during the cycle.
    task automatic modelStep(input bit r, input bit f, input bit rdy, input bit rv,
                             input logic [31:0] rd, input bit idr);
        bit idle;
        idle = !(m_req || m_wait || m_drain || m_hold || m_adv);
        if (m_adv && !f) pc_model = pc_model + 9'd1;
        if (f && redirect_on_flush) pc_model = 9'($urandom_range(0, 511));
        if (r) begin
            {m_req, m_wait, m_drain, m_hold, m_adv} = '0;
            m_addr  = '0;
            m_instr = '0;
            m_pc    = '0;
        end else if (idle) begin
            if (!f) begin
                m_req  = 1'b1;
                m_addr = pc_in;
            end
        end else if (m_req) begin
            if (f) begin
                m_req   = 1'b0;
                m_drain = rdy;
            end else if (rdy) begin
                m_req  = 1'b0;
                m_wait = 1'b1;
            end
        end else if (m_wait) begin
            if (rv) begin
                m_wait = 1'b0;
                if (!f) begin
                    m_hold  = 1'b1;
                    m_instr = rd;
                    m_pc    = m_addr;
                end
            end else if (f) begin
                m_wait  = 1'b0;
                m_drain = 1'b1;
            end
        end else if (m_hold) begin
            if (f) begin
                m_hold = 1'b0;
            end else if (idr) begin
                m_hold = 1'b0;
                m_adv  = 1'b1;
            end
        end else if (m_adv) begin
            m_adv = 1'b0;
        end else if (m_drain) begin
            if (rv) m_drain = 1'b0;
        end
    endtask

    // Runs one clock cycle.
    //   1. Drive the inputs on the falling edge.
    //   2. Compare every output with the model 1 ns later.
    //   3. Advance the model on the rising edge.
    task automatic applyStimulus(input bit r, input bit f, input bit rdy, input bit rv,
                                 input logic [31:0] rd, input bit idr);
        @(negedge clk);
        rst         = r;
        flush       = f;
        imem_ready  = rdy;
        imem_rvalid = rv;
        imem_rdata  = rd;
        id_ready    = idr;
        pc_in       = pc_model;
        #1;
        if (pc_en === 1'b1) pulses++;
        if (check_en) begin
            checkOutput("imem_req",  32'(imem_req),  32'(m_req));
            checkOutput("imem_addr", 32'(imem_addr), 32'(m_addr));
            checkOutput("id_valid",  32'(id_valid),  32'(m_hold));
            checkOutput("id_instr",  id_instr,       m_instr);
            checkOutput("id_pc",     32'(id_pc),     32'(m_pc));
            checkOutput("pc_en",     32'(pc_en),     32'(m_adv && !f));
        end
        @(posedge clk);
        modelStep(r, f, rdy, rv, rd, idr);
    endtask

    initial begin
        checks            = 0;
        fails             = 0;
        pulses            = 0;
        check_en          = 1'b0;
        redirect_on_flush = 1'b0;
        {m_req, m_wait, m_drain, m_hold, m_adv} = '0;
        m_addr   = '0;
        m_instr  = '0;
        m_pc     = '0;
        pc_model = '0;
        rst = 1'b1; flush = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0;
        imem_rdata = '0; id_ready = 1'b0; pc_in = '0;

        // Reset. The first cycle is not checked because its outputs are
        // still unknown. The second cycle checks the reset values.
        applyStimulus(1, 0, 0, 0, 32'h0, 0);
        check_en = 1'b1;
        applyStimulus(1, 0, 0, 0, 32'h0, 0);

        // Basic fetch at PC 0. id_valid should rise in cycle 4 and pc_en
        // should pulse once, in cycle 5.
        $display("[TB] basic fetch");
        pulses   = 0;
        pc_model = 9'h000;
        applyStimulus(0, 0, 1, 0, 32'h0, 0);
        applyStimulus(0, 0, 1, 0, 32'h0, 0);
        applyStimulus(0, 0, 1, 1, 32'h00A00093, 0);
        checkOutput("t1_no_early_valid", 32'(id_valid), 32'd0);
        applyStimulus(0, 0, 1, 0, 32'h0, 1);
        checkOutput("t1_id_pc", 32'(id_pc), 32'h000);
        applyStimulus(0, 0, 1, 0, 32'h0, 1);
        checkOutput("t1_pc_en_pulses", 32'(pulses), 32'd1);

        // Decode stalls for 6 cycles while the word is held.
        $display("[TB] decode stall");
        pulses = 0;
        applyStimulus(0, 0, 1, 0, 32'h0, 0);
        applyStimulus(0, 0, 1, 0, 32'h0, 0);
        applyStimulus(0, 0, 0, 1, 32'h12345678, 0);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 32'h0, 0);
        checkOutput("t2_no_pc_en_in_stall", 32'(pulses), 32'd0);
        applyStimulus(0, 0, 0, 0, 32'h0, 1);
        applyStimulus(0, 0, 0, 0, 32'h0, 0);
        checkOutput("t2_pc_en_pulses", 32'(pulses), 32'd1);

        // Memory withholds the grant for 3 cycles at address 0x005.
        $display("[TB] grant delay");
        pc_model = 9'h005;
        applyStimulus(0, 0, 0, 0, 32'h0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 32'h0, 0);
            checkOutput("t3_addr_steady", 32'(imem_addr), 32'h005);
        end
        applyStimulus(0, 0, 1, 0, 32'h0, 0);
        applyStimulus(0, 0, 0, 1, 32'hCAFEF00D, 0);
        applyStimulus(0, 0, 0, 0, 32'h0, 1);
        applyStimulus(0, 0, 0, 0, 32'h0, 0);

        // Flush in WAIT. The response arrives 2 cycles later and must be
        // dropped, and the next request uses the redirected PC.
        $display("[TB] flush in wait");
        pulses = 0;
        applyStimulus(0, 0, 0, 0, 32'h0, 0);
        applyStimulus(0, 0, 1, 0, 32'h0, 0);
        applyStimulus(0, 1, 0, 0, 32'h0, 0);
        pc_model = 9'h010;
        applyStimulus(0, 0, 0, 0, 32'h0, 0);
        applyStimulus(0, 0, 0, 1, 32'hDEADBEEF, 0);
        applyStimulus(0, 0, 0, 0, 32'h0, 0);
        applyStimulus(0, 0, 0, 0, 32'h0, 0);
        checkOutput("t4_redirect_addr", 32'(imem_addr), 32'h010);
        checkOutput("t4_no_pc_en", 32'(pulses), 32'd0);
        applyStimulus(0, 0, 1, 0, 32'h0, 0);
        applyStimulus(0, 0, 0, 1, 32'h00000013, 0);
        applyStimulus(0, 0, 0, 0, 32'h0, 1);
        applyStimulus(0, 0, 0, 0, 32'h0, 0);

        // Flush in HOLD in the same cycle that decode accepts.
        $display("[TB] flush in hold");
        pulses = 0;
        applyStimulus(0, 0, 0, 0, 32'h0, 0);
        applyStimulus(0, 0, 1, 0, 32'h0, 0);
        applyStimulus(0, 0, 0, 1, 32'h00100073, 0);
        applyStimulus(0, 1, 0, 0, 32'h0, 1);
        applyStimulus(0, 0, 0, 0, 32'h0, 0);
        checkOutput("t5_no_pc_en", 32'(pulses), 32'd0);

        // Reset in WAIT. The stale response that follows must be ignored.
        $display("[TB] reset in wait");
        applyStimulus(0, 0, 1, 0, 32'h0, 0);
        applyStimulus(0, 0, 0, 0, 32'h0, 0);
        applyStimulus(1, 0, 0, 0, 32'h0, 0);
        applyStimulus(0, 0, 0, 1, 32'hBADC0FFE, 0);
        checkOutput("t6_instr_cleared", id_instr, 32'h0);
        applyStimulus(0, 0, 1, 0, 32'h0, 0);
        applyStimulus(0, 0, 0, 1, 32'h00500113, 0);
        applyStimulus(0, 0, 0, 0, 32'h0, 1);
        applyStimulus(0, 0, 0, 0, 32'h0, 0);

        // Randomized traffic. Memory and decode handshakes are random, flush
        // and reset are occasional, and a flush redirects the PC.
        $display("[TB] random traffic");
        redirect_on_flush = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            applyStimulus(($urandom % 150) == 0,
                          ($urandom % 14) == 0,
                          $urandom_range(0, 1) == 1,
                          ($urandom % 3) == 0,
                          $urandom,
                          $urandom_range(0, 1) == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
